io_request_ctrl: RTL and testbench
==================================

# io_request_ctrl

Sequencer that arbitrates CPU I/O requests against the board's human-paced inputs. It sits between the CPU core (which drives the syscall code from register a7) and the memory/I/O steering logic. For input codes it stalls the core until a debounced press of the confirm button, then captures the synchronized switch or test-index value. For output codes it updates the LED register in one cycle.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 20'd1_000_000: cycles the synchronized button must hold a new level before the clean level changes (minimum 1).
- CNT_W, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- io_req  in  1  CPU I/O request; held high until io_done.
- io_code  in  32  request code (a7 value), sampled in IDLE when io_req=1.
- wdata  in  32  register data for output codes.
- switch_in  in  8  raw switch bank (asynchronous).
- test_index  in  3  raw test-select switches (asynchronous).
- confirm_btn  in  1  raw confirm button (asynchronous, bouncing).
- stall  out  1  freeze PC/pipeline; combinational.
- io_done  out  1  one-cycle completion pulse; rdata valid in the same cycle.
- rdata  out  32  result to the register-file write mux.
- led_out  out  16  LED register.
- confirm_clean  out  1  debounced button level (status/debug).

## Operation
- Synchronizers: 2-FF chains on confirm_btn, switch_in, and test_index. All decisions use the synchronized values.
- Debounce: when the synchronized button differs from confirm_clean, the counter increments. When it equals confirm_clean, the counter clears. When the counter reaches DEBOUNCE_CYCLES-1, confirm_clean toggles and the counter clears. press = confirm_clean rising edge, registered and one cycle wide.
- Code classes:
  - Immediate: 0 returns {31'b0, confirm_clean}. 4 sets led_out <= wdata[15:0]. 5 sets led_out <= 16'h0000. Any other unknown code returns rdata = 0 with no side effect.
  - Wait: 1 returns sign-extended switches. 2 returns {29'b0, test_index}. 3 returns zero-extended switches.
- FSM states: IDLE, WAIT_RELEASE, WAIT_PRESS, CAPTURE, DONE.
  - IDLE, io_req=1: latch the code. An immediate code computes rdata / updates led_out and goes to DONE. A wait code goes to WAIT_RELEASE if confirm_clean=1, otherwise to WAIT_PRESS.
  - WAIT_RELEASE: go to WAIT_PRESS when confirm_clean=0. This prevents a held press from satisfying consecutive reads.
  - WAIT_PRESS: go to CAPTURE on press.
  - CAPTURE: load rdata from the synchronized inputs, then go to DONE.
  - DONE: io_done=1, then go to IDLE.
- stall = io_req & (state != DONE).
- Abort: io_req=0 in WAIT_RELEASE, WAIT_PRESS, or CAPTURE returns to IDLE. In that case there is no io_done and rdata and led_out keep their values.
- rdata holds its last value outside DONE.
- Reset values: state IDLE, rdata 0, led_out 0, io_done 0, confirm_clean 0, counter 0, sync flops 0. stall follows io_req during reset.

## Timing
- Immediate code: io_req sampled in IDLE at edge N; io_done and rdata valid in cycle N+1. led_out changes at edge N, so it is visible in cycle N+1.
- Wait code: press high in cycle k, CAPTURE in cycle k+1, io_done in cycle k+2.
- Button latency: a raw level change reaches confirm_clean after 2 + DEBOUNCE_CYCLES cycles if stable. A bounce shorter than DEBOUNCE_CYCLES cycles never changes confirm_clean.
- Switch values are sampled in CAPTURE, so the switch must be stable for 2 cycles before that.
- Back-to-back: io_req may stay high after DONE. The next request is accepted in the IDLE cycle that follows, so there is a minimum spacing of 2 cycles per immediate request.
- Asynchronous rst mid-wait: FSM goes to IDLE at once and io_done is never asserted.

## Test plan
Run with DEBOUNCE_CYCLES=4.
- Reset state: assert rst mid-cycle -> all outputs 0 immediately. With io_req=1 during rst, stall=1.
- LED write: code 4, wdata=32'h1234_ABCD -> led_out=16'hABCD and io_done=1 one cycle later, stall low in that cycle. Then code 5 -> led_out=0.
- Signed switch read: switch_in=8'h85, code 1, clean button press -> io_done 2 cycles after press, rdata=32'hFFFF_FF85. Code 3 with the same switches -> 32'h0000_0085.
- Bounce rejection: during code 2 wait, toggle the button with 2-cycle pulses -> no io_done, stall stays high. A stable press with test_index=3'd5 -> rdata=32'd5.
- Held button: button already clean-high when code 1 arrives -> stays in WAIT_RELEASE. Release then press again -> only then io_done.
- Abort/unknown: drop io_req in WAIT_PRESS -> IDLE, no io_done, rdata unchanged. Code 9 -> io_done next cycle, rdata=0.

Source files
------------

// File: rtl/io_request_ctrl.sv
// io_request_ctrl
// Sequences CPU I/O syscalls against the board's human-paced inputs.
// Input codes stall the core until a debounced press of the confirm button,
// then capture the synchronized switch or test-index value. Output codes
// update the LED register in one cycle.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   io_req         CPU I/O request, held high until io_done
//   io_code        request code (a7), sampled in IDLE
//   wdata          register data for output codes
//   switch_in      raw switch bank (asynchronous)
//   test_index     raw test-select switches (asynchronous)
//   confirm_btn    raw confirm button (asynchronous, bouncing)
//   stall          freeze PC/pipeline (combinational)
//   io_done        one-cycle completion pulse, rdata valid with it
//   rdata          result to the register-file write mux
//   led_out        LED register
//   confirm_clean  debounced button level

module io_request_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_req,
    input  logic [31:0] io_code,
    input  logic [31:0] wdata,
    input  logic [7:0]  switch_in,
    input  logic [2:0]  test_index,
    input  logic        confirm_btn,
    output logic        stall,
    output logic        io_done,
    output logic [31:0] rdata,
    output logic [15:0] led_out,
    output logic        confirm_clean
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RELEASE,
        S_WAIT_PRESS,
        S_CAPTURE,
        S_DONE
    } state_t;

    // Which synchronized source a pending wait request will capture.
    typedef enum logic [1:0] {
        SEL_SW_SIGNED,
        SEL_TEST_INDEX,
        SEL_SW_UNSIGNED
    } sel_t;

    state_t           state;
    sel_t             sel_q;
    logic             btn_s1, btn_s2;
    logic [7:0]       sw_s1, sw_s2;
    logic [2:0]       ti_s1, ti_s2;
    logic [CNT_W-1:0] db_cnt;
    logic             press;

    // Upper write-data bits have no LED to drive.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[31:16];

    // The core freezes for the whole request except the completion cycle.
    assign stall = io_req & (state != S_DONE);

    // Two-flop synchronizers for every asynchronous board input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sw_s1  <= 8'h00;
            sw_s2  <= 8'h00;
            ti_s1  <= 3'd0;
            ti_s2  <= 3'd0;
        end else begin
            btn_s1 <= confirm_btn;
            btn_s2 <= btn_s1;
            sw_s1  <= switch_in;
            sw_s2  <= sw_s1;
            ti_s1  <= test_index;
            ti_s2  <= ti_s1;
        end
    end

    // Debounce: the clean level flips only after the synchronized button has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles. press marks
    // the cycle in which the clean level first reads high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt        <= '0;
            confirm_clean <= 1'b0;
            press         <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_s2 != confirm_clean) begin
                if (db_cnt == DB_LAST) begin
                    db_cnt        <= '0;
                    confirm_clean <= ~confirm_clean;
                    press         <= ~confirm_clean;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Request sequencer. Wait codes that arrive while the button is still
    // held must first see a release, so one press cannot serve two reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            sel_q   <= SEL_SW_SIGNED;
            rdata   <= 32'h0000_0000;
            led_out <= 16'h0000;
            io_done <= 1'b0;
        end else begin
            io_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (io_req) begin
                        case (io_code)
                            32'd0: begin
                                rdata   <= {31'b0, confirm_clean};
                                io_done <= 1'b1;
                                state   <= S_DONE;
                            end
                            32'd1: begin
                                sel_q <= SEL_SW_SIGNED;
                                state <= confirm_clean ? S_WAIT_RELEASE : S_WAIT_PRESS;
                            end
                            32'd2: begin
                                sel_q <= SEL_TEST_INDEX;
                                state <= confirm_clean ? S_WAIT_RELEASE : S_WAIT_PRESS;
                            end
                            32'd3: begin
                                sel_q <= SEL_SW_UNSIGNED;
                                state <= confirm_clean ? S_WAIT_RELEASE : S_WAIT_PRESS;
                            end
                            32'd4: begin
                                led_out <= wdata[15:0];
                                rdata   <= 32'h0000_0000;
                                io_done <= 1'b1;
                                state   <= S_DONE;
                            end
                            32'd5: begin
                                led_out <= 16'h0000;
                                rdata   <= 32'h0000_0000;
                                io_done <= 1'b1;
                                state   <= S_DONE;
                            end
                            default: begin
                                rdata   <= 32'h0000_0000;
                                io_done <= 1'b1;
                                state   <= S_DONE;
                            end
                        endcase
                    end
                end

                S_WAIT_RELEASE: begin
                    if (!io_req) begin
                        state <= S_IDLE;
                    end else if (!confirm_clean) begin
                        state <= S_WAIT_PRESS;
                    end
                end

                S_WAIT_PRESS: begin
                    if (!io_req) begin
                        state <= S_IDLE;
                    end else if (press) begin
                        state <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    if (!io_req) begin
                        state <= S_IDLE;
                    end else begin
                        case (sel_q)
                            SEL_SW_SIGNED:  rdata <= {{24{sw_s2[7]}}, sw_s2};
                            SEL_TEST_INDEX: rdata <= {29'b0, ti_s2};
                            default:        rdata <= {24'b0, sw_s2};
                        endcase
                        io_done <= 1'b1;
                        state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_request_ctrl.sv
// Self-checking bench for io_request_ctrl with a 4-cycle debounce.
module tb_io_request_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned CW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_req;
    logic [31:0] io_code;
    logic [31:0] wdata;
    logic [7:0]  switch_in;
    logic [2:0]  test_index;
    logic        confirm_btn;
    logic        stall;
    logic        io_done;
    logic [31:0] rdata;
    logic [15:0] led_out;
    logic        confirm_clean;

    io_request_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .io_req       (io_req),
        .io_code      (io_code),
        .wdata        (wdata),
        .switch_in    (switch_in),
        .test_index   (test_index),
        .confirm_btn  (confirm_btn),
        .stall        (stall),
        .io_done      (io_done),
        .rdata        (rdata),
        .led_out      (led_out),
        .confirm_clean(confirm_clean)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        bit          check_rdata;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request on the next falling edge; optionally queue its result.
    task automatic start_req(input logic [31:0] code, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input bit chk_rd,
                             input bit push, input string tag);
        exp_t e;
        @(negedge clk);
        if (push) begin
            e.tag = tag;
            e.rdata = exp_rd;
            e.check_rdata = chk_rd;
            sb.push_back(e);
        end
        io_code = code;
        wdata   = wd;
        io_req  = 1'b1;
    endtask

    // Wait for io_done, pop the scoreboard and compare; returns cycles taken.
    task automatic wait_done(input int budget, output int lat);
        exp_t e;
        bit   seen = 1'b0;
        bit   stall_ok = 1'b1;
        lat = -1;
        for (int i = 1; i <= budget && !seen; i++) begin
            @(negedge clk);
            if (io_done === 1'b1) begin
                seen = 1'b1;
                lat  = i;
                chk("done with request queued", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    if (e.check_rdata) chk({e.tag, " rdata"}, rdata, e.rdata);
                    chk({e.tag, " stall in done"}, 32'(stall), 32'd0);
                end
                io_req = 1'b0;
            end else if (stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        chk("stall while pending", 32'(stall_ok), 32'd1);
        chk("io_done seen", 32'(seen), 32'd1);
        if (!seen) begin
            if (sb.size() != 0) void'(sb.pop_front());
            io_req = 1'b0;
        end
    endtask

    // n cycles in which no completion may appear and stall must track io_req.
    task automatic quiet(input int n, input string tag);
        bit ok = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (io_done !== 1'b0 || stall !== io_req) ok = 1'b0;
        end
        chk({tag, " quiet"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_clean(input logic lvl, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget && lat < 0; i++) begin
            @(negedge clk);
            if (confirm_clean === lvl) lat = i;
        end
        chk("confirm_clean reached", 32'(lat > 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        rst = 1'b1; io_req = 1'b1; io_code = 32'd0; wdata = 32'd0;
        switch_in = 8'h00; test_index = 3'd0; confirm_btn = 1'b0;
        #1;
        chk("reset stall follows req", 32'(stall), 32'd1);
        chk("reset io_done", 32'(io_done), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset led_out", 32'(led_out), 32'd0);
        chk("reset confirm_clean", 32'(confirm_clean), 32'd0);
        io_req = 1'b0;
        #1;
        chk("reset stall low", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // LED write and clear
        start_req(32'd4, 32'h1234_ABCD, 32'd0, 1'b0, 1'b1, "led write");
        wait_done(4, lat);
        chk("led write latency", 32'(lat), 32'd1);
        chk("led write value", 32'(led_out), 32'h0000_ABCD);
        start_req(32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, "led clear");
        wait_done(4, lat);
        chk("led clear value", 32'(led_out), 32'd0);
        start_req(32'd0, 32'd0, 32'd0, 1'b1, 1'b1, "read clean low");
        wait_done(4, lat);

        // Signed switch read with a clean press
        switch_in = 8'h85; test_index = 3'd6;
        start_req(32'd1, 32'd0, 32'hFFFF_FF85, 1'b1, 1'b1, "switch signed");
        quiet(4, "wait press");
        confirm_btn = 1'b1;
        wait_clean(1'b1, 12, lat);
        chk("button latency", 32'(lat), 32'(2 + DB));
        wait_done(6, lat);
        chk("press to done", 32'(lat >= 2 && lat <= 3), 32'd1);
        confirm_btn = 1'b0;
        wait_clean(1'b0, 12, lat);

        // Unsigned switch read
        start_req(32'd3, 32'd0, 32'h0000_0085, 1'b1, 1'b1, "switch unsigned");
        quiet(2, "wait press 2");
        confirm_btn = 1'b1;
        wait_clean(1'b1, 12, lat);
        wait_done(6, lat);
        confirm_btn = 1'b0;
        wait_clean(1'b0, 12, lat);

        // Bounce rejection, then a stable press for test_index
        test_index = 3'd5;
        start_req(32'd2, 32'd0, 32'd5, 1'b1, 1'b1, "test index");
        for (int i = 0; i < 4; i++) begin
            confirm_btn = 1'b1;
            quiet(2, "bounce high");
            confirm_btn = 1'b0;
            quiet(2, "bounce low");
        end
        quiet(4, "bounce settle");
        chk("bounce clean stays low", 32'(confirm_clean), 32'd0);
        confirm_btn = 1'b1;
        wait_clean(1'b1, 12, lat);
        wait_done(6, lat);

        // Unknown code clears rdata
        start_req(32'd9, 32'd0, 32'd0, 1'b1, 1'b1, "unknown code");
        wait_done(4, lat);
        chk("unknown latency", 32'(lat), 32'd1);

        // Back-to-back immediate requests with io_req held
        start_req(32'd4, 32'h0000_00F0, 32'd0, 1'b0, 1'b0, "");
        @(negedge clk);
        chk("b2b first done", 32'(io_done), 32'd1);
        chk("b2b led", 32'(led_out), 32'h0000_00F0);
        @(negedge clk);
        chk("b2b gap done", 32'(io_done), 32'd0);
        chk("b2b gap stall", 32'(stall), 32'd1);
        @(negedge clk);
        chk("b2b second done", 32'(io_done), 32'd1);
        io_req = 1'b0;

        // Held button: read must wait for release then a fresh press
        switch_in = 8'h3C;
        start_req(32'd1, 32'd0, 32'h0000_003C, 1'b1, 1'b1, "held button");
        quiet(10, "held");
        confirm_btn = 1'b0;
        quiet(10, "released");
        confirm_btn = 1'b1;
        wait_clean(1'b1, 12, lat);
        wait_done(6, lat);
        start_req(32'd0, 32'd0, 32'd1, 1'b1, 1'b1, "read clean high");
        wait_done(4, lat);
        confirm_btn = 1'b0;
        wait_clean(1'b0, 12, lat);

        // Abort in WAIT_PRESS
        switch_in = 8'hAA;
        start_req(32'd3, 32'd0, 32'd0, 1'b0, 1'b0, "");
        quiet(4, "abort wait");
        io_req = 1'b0;
        quiet(4, "abort");
        chk("abort rdata kept", rdata, 32'd1);
        confirm_btn = 1'b1;
        quiet(12, "press after abort");
        chk("abort rdata still kept", rdata, 32'd1);
        confirm_btn = 1'b0;
        wait_clean(1'b0, 12, lat);

        // Asynchronous reset mid-wait
        start_req(32'd1, 32'd0, 32'd0, 1'b0, 1'b0, "");
        quiet(3, "pre reset");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset rdata", rdata, 32'd0);
        chk("midreset led", 32'(led_out), 32'd0);
        chk("midreset io_done", 32'(io_done), 32'd0);
        chk("midreset stall", 32'(stall), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        io_req = 1'b0;
        confirm_btn = 1'b1;
        quiet(12, "after reset");

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
